rtc_bus_ctrl: RTL

Physical bus engine for the RTC chip. Sits directly downstream of the RTC request multiplexer: it takes one selected transaction request (start, read/write, address, write data), runs the multiplexed address/data bus cycle on the RTC pins, and returns busy (`rtc_work`), a read-done strobe (`tome`) and the read byte. It executes one access at a time; all arbitration between init, time, date, timer and readback happens upstream.

---
 rtl/rtc_bus_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/rtc_bus_ctrl.sv
// Multiplexed address/data bus engine for the RTC chip: runs one read or write
// cycle (address phase, then data phase) per accepted request.
module rtc_bus_ctrl #(
    parameter int unsigned PULSE_CYC = 10,
    parameter int unsigned GAP_CYC   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trabaje,
    input  logic       lea_escriba,
    input  logic [7:0] direcion,
    input  logic [7:0] dato_in,
    output logic       rtc_work,
    output logic       tome,
    output logic [7:0] dato_out,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_SETUP,
        ADDR_STROBE,
        ADDR_HOLD,
        DATA_SETUP,
        DATA_STROBE,
        DATA_HOLD
    } state_t;

    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       rd_sel_q, rd_sel_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rbyte_q, rbyte_d;
    logic       rtc_work_q, rtc_work_d;
    logic       tome_q, tome_d;
    logic [7:0] dato_out_q, dato_out_d;
    logic       cs_n_q, cs_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       a_d_q, a_d_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       ad_oe_q, ad_oe_d;

    // Sequencing: each non-idle state runs its reload count down to zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_sel_d   = rd_sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rbyte_d    = rbyte_q;
        rtc_work_d = rtc_work_q;
        tome_d     = 1'b0;
        dato_out_d = dato_out_q;

        if (state_q == IDLE) begin
            if (trabaje) begin
                rd_sel_d   = lea_escriba;
                addr_d     = direcion;
                wdata_d    = dato_in;
                rtc_work_d = 1'b1;
                state_d    = ADDR_SETUP;
                cnt_d      = GAP_LD;
            end
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end else begin
            case (state_q)
                ADDR_SETUP: begin
                    state_d = ADDR_STROBE;
                    cnt_d   = PULSE_LD;
                end
                ADDR_STROBE: begin
                    state_d = ADDR_HOLD;
                    cnt_d   = GAP_LD;
                end
                ADDR_HOLD: begin
                    state_d = DATA_SETUP;
                    cnt_d   = GAP_LD;
                end
                DATA_SETUP: begin
                    state_d = DATA_STROBE;
                    cnt_d   = PULSE_LD;
                end
                DATA_STROBE: begin
                    state_d = DATA_HOLD;
                    cnt_d   = GAP_LD;
                    if (rd_sel_q) begin
                        rbyte_d = ad_in;
                    end
                end
                DATA_HOLD: begin
                    state_d    = IDLE;
                    cnt_d      = 8'd0;
                    rtc_work_d = 1'b0;
                    tome_d     = rd_sel_q;
                    if (rd_sel_q) begin
                        dato_out_d = rbyte_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Pin values are decoded from the next state so every pin is a flop output.
    always_comb begin
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        a_d_d    = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = ad_out_q;

        case (state_d)
            ADDR_SETUP, ADDR_HOLD: begin
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
            end
            ADDR_STROBE: begin
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
            end
            DATA_SETUP, DATA_HOLD: begin
                if (!rd_sel_d) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                end
            end
            DATA_STROBE: begin
                cs_n_d = 1'b0;
                if (rd_sel_d) begin
                    rd_n_d = 1'b0;
                end else begin
                    wr_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                end
            end
            default: begin
                ad_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_sel_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rbyte_q    <= '0;
            rtc_work_q <= 1'b0;
            tome_q     <= 1'b0;
            dato_out_q <= '0;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            a_d_q      <= 1'b1;
            ad_out_q   <= '0;
            ad_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_sel_q   <= rd_sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rbyte_q    <= rbyte_d;
            rtc_work_q <= rtc_work_d;
            tome_q     <= tome_d;
            dato_out_q <= dato_out_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            a_d_q      <= a_d_d;
            ad_out_q   <= ad_out_d;
            ad_oe_q    <= ad_oe_d;
        end
    end

    assign rtc_work = rtc_work_q;
    assign tome     = tome_q;
    assign dato_out = dato_out_q;
    assign cs_n     = cs_n_q;
    assign rd_n     = rd_n_q;
    assign wr_n     = wr_n_q;
    assign a_d      = a_d_q;
    assign ad_out   = ad_out_q;
    assign ad_oe    = ad_oe_q;

endmodule
